// File: rtl/serial_transmitter_param.sv
`default_nettype none
// ============================================================================
// Module      : serial_transmitter_param
// Description : Parametrised async serial transmitter (start, data LSB first,
//               optional parity via SERIAL_TX_PARITY_EN, stop bits).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_transmitter_param #(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int DIV        = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 dav_,
    input  logic [DATA_BITS-1:0] tx_byte,
    output logic                 rfd,
    output logic                 txd
);

`ifdef SERIAL_TX_PARITY_EN
    localparam int c_PAR_BITS = 1;
`else
    localparam int c_PAR_BITS = 0;
`endif

    localparam int c_FRAME_LEN = 1 + DATA_BITS + c_PAR_BITS + STOP_BITS;
    // The start bit is driven directly at accept, so only the rest is stored.
    localparam int c_SHIFT_W   = c_FRAME_LEN - 1;
    localparam int c_BIT_CNT_W = $clog2(c_FRAME_LEN + 1);
    localparam int c_CELL_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CELL_W-1:0]    c_CELL_MAX  = c_CELL_W'(DIV - 1);
    localparam logic [c_BIT_CNT_W-1:0] c_BIT_LOAD  = c_BIT_CNT_W'(c_FRAME_LEN);
    localparam logic [c_BIT_CNT_W-1:0] c_BIT_LAST  = c_BIT_CNT_W'(1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("STOP_BITS must be 1..2");
    end
    if (DIV < 1) begin : g_bad_div
        $error("DIV must be >= 1");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
        $error("PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                   r_state, w_state_nxt;
    logic [c_SHIFT_W-1:0]     r_frame, w_frame_nxt;
    logic [c_BIT_CNT_W-1:0]   r_bit_cnt, w_bit_cnt_nxt;
    logic [c_CELL_W-1:0]      r_cell, w_cell_nxt;
    logic                     r_txd, w_txd_nxt;
    logic                     r_rfd, w_rfd_nxt;
    logic [c_SHIFT_W-1:0]     w_payload;

`ifdef SERIAL_TX_PARITY_EN
    logic w_parity;
    assign w_parity  = (^tx_byte) ^ (PARITY_ODD != 0);
    assign w_payload = {{STOP_BITS{1'b1}}, w_parity, tx_byte};
`else
    assign w_payload = {{STOP_BITS{1'b1}}, tx_byte};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_frame   <= '1;
            r_bit_cnt <= '0;
            r_cell    <= '0;
            r_txd     <= 1'b1;
            r_rfd     <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_frame   <= w_frame_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_cell    <= w_cell_nxt;
            r_txd     <= w_txd_nxt;
            r_rfd     <= w_rfd_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_frame_nxt   = r_frame;
        w_bit_cnt_nxt = r_bit_cnt;
        w_cell_nxt    = r_cell;
        w_txd_nxt     = r_txd;
        w_rfd_nxt     = r_rfd;
        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                w_rfd_nxt = 1'b1;
                if (!dav_) begin
                    w_frame_nxt   = w_payload;
                    w_txd_nxt     = 1'b0;
                    w_rfd_nxt     = 1'b0;
                    w_bit_cnt_nxt = c_BIT_LOAD;
                    w_cell_nxt    = c_CELL_MAX;
                    w_state_nxt   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_rfd_nxt = 1'b0;
                if (r_cell == '0) begin
                    w_cell_nxt    = c_CELL_MAX;
                    w_bit_cnt_nxt = r_bit_cnt - 1'b1;
                    if (r_bit_cnt == c_BIT_LAST) begin
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_txd_nxt   = r_frame[0];
                        w_frame_nxt = {1'b1, r_frame[c_SHIFT_W-1:1]};
                    end
                end else begin
                    w_cell_nxt = r_cell - 1'b1;
                end
            end
            S_WAIT: begin
                w_txd_nxt = 1'b1;
                w_rfd_nxt = 1'b0;
                // Producer must release dav_ before another word is taken.
                if (dav_) begin
                    w_rfd_nxt   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_txd_nxt   = 1'b1;
                w_rfd_nxt   = 1'b1;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign txd = r_txd;
    assign rfd = r_rfd;

endmodule
`default_nettype wire
